// File: rtl/scoreboarded_register_file_if.sv
// Bundles the write, reserve and read buses of the scoreboarded register file.
// The master drives writes, reservations and read addresses; the slave is the register file.
interface scoreboarded_register_file_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int READ_PORTS    = 2
);
  logic                                write_enable;
  logic [ADDRESS_WIDTH-1:0]            write_address;
  logic [DATA_WIDTH-1:0]               write_data;
  logic                                reserve_enable;
  logic [ADDRESS_WIDTH-1:0]            reserve_address;
  logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_address;
  logic [READ_PORTS*DATA_WIDTH-1:0]    read_data;
  logic [READ_PORTS-1:0]               read_pending;
  logic [ADDRESS_WIDTH:0]              pending_count;

  modport master (
    output write_enable, write_address, write_data,
    output reserve_enable, reserve_address, read_address,
    input  read_data, read_pending, pending_count
  );

  modport slave (
    input  write_enable, write_address, write_data,
    input  reserve_enable, reserve_address, read_address,
    output read_data, read_pending, pending_count
  );
endinterface

// File: rtl/scoreboarded_register_file.sv
// Register file with combinational read ports, one write port, optional write bypass
// and a per-register pending scoreboard for RAW hazard detection. r0 is always zero.
module scoreboarded_register_file #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_COUNT = 32,
  parameter int ADDRESS_WIDTH  = $clog2(REGISTER_COUNT),
  parameter int READ_PORTS     = 2,
  parameter int WRITE_BYPASS   = 1
) (
  input logic                          system_clock,
  input logic                          system_reset,
  scoreboarded_register_file_if.slave  bus
);

  logic [DATA_WIDTH-1:0]     r_regs [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0] r_pending;
  logic [ADDRESS_WIDTH:0]    r_pending_count;
  logic [REGISTER_COUNT-1:0] w_pending_next;
  logic                      w_write_hit;
  logic                      w_reserve_hit;

  function automatic logic [ADDRESS_WIDTH:0] popcount(input logic [REGISTER_COUNT-1:0] v);
    logic [ADDRESS_WIDTH:0] c;
    c = '0;
    for (int i = 0; i < REGISTER_COUNT; i++) begin
      c = c + {{ADDRESS_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign w_write_hit   = bus.write_enable && (bus.write_address != '0);
  assign w_reserve_hit = bus.reserve_enable && (bus.reserve_address != '0);

  // Reserve is applied after the write clear so it wins on a same-address collision.
  always_comb begin
    w_pending_next = r_pending;
    if (w_write_hit) begin
      w_pending_next[bus.write_address] = 1'b0;
    end
    if (w_reserve_hit) begin
      w_pending_next[bus.reserve_address] = 1'b1;
    end
  end

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      for (int i = 0; i < REGISTER_COUNT; i++) begin
        r_regs[i] <= '0;
      end
      r_pending       <= '0;
      r_pending_count <= '0;
    end else begin
      if (w_write_hit) begin
        r_regs[bus.write_address] <= bus.write_data;
      end
      r_pending       <= w_pending_next;
      r_pending_count <= popcount(w_pending_next);
    end
  end

  assign bus.pending_count = r_pending_count;

  // A bypassed operand is reported ready even if it is being re-reserved this cycle.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic                     w_zero;
    logic                     w_bypass;

    assign w_addr   = bus.read_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_zero   = system_reset || (w_addr == '0);
    assign w_bypass = (WRITE_BYPASS != 0) && bus.write_enable && (bus.write_address == w_addr);

    assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] =
      w_zero   ? '0 :
      w_bypass ? bus.write_data :
                 r_regs[w_addr];
    assign bus.read_pending[p] = !w_zero && !w_bypass && r_pending[w_addr];
  end

endmodule

// File: doc/scoreboarded_register_file.md
# scoreboarded_register_file

Parametrised general-purpose register file for the pipelined datapath. It provides READ_PORTS combinational read ports and one clocked write port, with optional write-to-read bypass. An integrated per-register pending scoreboard lets decode detect RAW hazards against in-flight writebacks. Register 0 is hard-wired to zero and is never pending.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register
- REGISTER_COUNT, 32, number of registers (power of two, ≥ 2)
- ADDRESS_WIDTH, $clog2(REGISTER_COUNT), register address width
- READ_PORTS, 2, number of independent read ports (≥ 1)
- WRITE_BYPASS, 1, 1 = a read of the address being written this cycle returns write_data; 0 = returns the stored value

Ports:
- system_clock  input  1  single clock; all state updates on rising edge
- system_reset  input  1  asynchronous, active-high; clears all registers and the scoreboard
- write_enable  input  1  commit write_data to write_address at the next edge; also clears that register's pending bit
- write_address  input  ADDRESS_WIDTH  writeback destination
- write_data  input  DATA_WIDTH  writeback value
- reserve_enable  input  1  mark reserve_address pending at the next edge (issue of a producing instruction)
- reserve_address  input  ADDRESS_WIDTH  destination being reserved
- read_address  input  READ_PORTS*ADDRESS_WIDTH  packed; port i at bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- read_data  output  READ_PORTS*DATA_WIDTH  packed, same port ordering
- read_pending  output  READ_PORTS  bit i = operand on port i not yet written back
- pending_count  output  ADDRESS_WIDTH+1  number of registers currently pending

## Operation
- Storage: REGISTER_COUNT × DATA_WIDTH array plus a REGISTER_COUNT-bit pending vector.
- Write: on the edge with write_enable=1 and write_address≠0, register[write_address] ← write_data and pending[write_address] ← 0. Writes to address 0 are ignored.
- Reserve: on the edge with reserve_enable=1 and reserve_address≠0, pending[reserve_address] ← 1. Reserving address 0 is ignored.
- Reserve and write on the same edge and same address: the reserve wins (pending=1) and the data is still written. Different addresses: both take effect.
- Reserving an already-pending register leaves it pending (no nesting).
- Writing a non-pending register is legal: data is stored and pending stays 0.
- Read port i (combinational):
  - address 0: data 0, pending 0.
  - WRITE_BYPASS=1, write_enable=1 and write_address==address≠0: data = write_data, pending = 0 (unless a reserve to the same address is also present this cycle; pending is then still reported 0, because the value read is valid for the current consumer).
  - otherwise: data = register[address], pending = pending[address].
  - WRITE_BYPASS=0: no forwarding; the stored value and the stored pending bit are returned.
- pending_count: registered population count of the pending vector, updated on the same edge as the vector. It is never > REGISTER_COUNT−1.
- Reset (asynchronous, any time, including mid-operation): all registers = 0, pending = 0, pending_count = 0 immediately on assertion. A write or reserve coincident with the reset edge is discarded. While reset is held, all read_data = 0, read_pending = 0, and edges have no effect.

## Timing
- Write latency: data is visible via the array one cycle after the write edge; with bypass it is visible in the same cycle as write_enable.
- Reserve latency: pending is visible one cycle after the reserve edge.
- Read path: purely combinational from read_address/write inputs to read_data/read_pending; there is no clock-to-read latency.
- pending_count changes on the edge only; it has no combinational path from inputs.
- Reset deassertion: the first effective edge is the first rising edge after system_reset falls.

## Test plan
- Reset: write 0xDEADBEEF to r5, reserve r7, assert system_reset mid-cycle → read_data(r5)=0, read_pending(r7)=0 and pending_count=0 immediately, before any edge.
- Basic write/read on all ports: write r1=0x11111111 and r31=0xFFFF0000; read r1 on port 0 and r31 on port 1 next cycle → values match. Write r0=0x12345678 → r0 reads 0.
- Bypass: WRITE_BYPASS=1, write_enable with r3=0xA5A5A5A5 while port 0 reads r3 (old value 0) → same cycle read_data=0xA5A5A5A5. WRITE_BYPASS=0 build → returns 0 in that cycle and 0xA5A5A5A5 in the next.
- Scoreboard: reserve r4 → next cycle read_pending[r4]=1, pending_count=1. Write r4=7 → bypass cycle reports pending 0, next cycle stored pending 0, count=0.
- Simultaneous reserve and write on r9 → r9 holds write_data and stays pending, count unchanged if already pending. Reserve r0 → count stays 0.
- Parameter sweep: DATA_WIDTH=16, REGISTER_COUNT=8, READ_PORTS=3; reserve r1–r7 over 7 cycles → pending_count=7; random write/read sequence matches the reference model.
